// File: rtl/key_entry_if.sv
// ----------------------------------------------------------------------------
// key_entry_if
// Bundles the numpad event input, the live operand view and the
// operand/operator record handshake of key_entry.
//   key         numpad event {is_changed, keyboard, btn[3:0]}
//   entry       current operand, 8 BCD digits, digit 0 in [3:0]
//   entry_neg   sign of the current operand
//   digit_count number of entered digits, 0..8
//   overflow    sticky: a digit was rejected with 8 digits present
//   out_valid   record available
//   out_ready   downstream accepts the record
//   out_operand BCD operand of the record
//   out_neg     sign of the record
//   out_op      operator: 0 add, 1 sub, 2 mul, 3 div, 4 equals
//   dropped     one-cycle pulse when a key is discarded while a record waits
// master: the key_entry side. slave: the producer of keys / record consumer.
// ----------------------------------------------------------------------------
interface key_entry_if;
  logic [5:0]  key;
  logic [31:0] entry;
  logic        entry_neg;
  logic [3:0]  digit_count;
  logic        overflow;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand;
  logic        out_neg;
  logic [2:0]  out_op;
  logic        dropped;

  modport master (
    input  key, out_ready,
    output entry, entry_neg, digit_count, overflow,
           out_valid, out_operand, out_neg, out_op, dropped
  );

  modport slave (
    output key, out_ready,
    input  entry, entry_neg, digit_count, overflow,
           out_valid, out_operand, out_neg, out_op, dropped
  );
endinterface

// File: rtl/key_entry.sv
// ----------------------------------------------------------------------------
// key_entry
// Calculator operand entry from numpad events. Digits are shifted into an
// 8-digit BCD operand; an operator key publishes {operand, sign, operator}
// as a record held until a valid/ready handshake, after which a fresh
// operand is started.
// Ports:
//   clock  system clock, all state updates on the rising edge
//   reset  synchronous active-high reset
//   bus    key_entry_if.master (key event in, operand view and record out)
// Build option:
//   KEY_ENTRY_ALT_EN  when defined, the alternate keyboard provides
//                     backspace (glyph 1) and sign toggle (glyph 0);
//                     when undefined, alternate keys are ignored and the
//                     sign outputs stay 0.
// ----------------------------------------------------------------------------
module key_entry (
  input  logic         clock,
  input  logic         reset,
  key_entry_if.master  bus
);

`ifdef KEY_ENTRY_ALT_EN
  localparam bit ALT_EN = 1'b1;
`else
  localparam bit ALT_EN = 1'b0;
`endif

  typedef enum logic {ST_ENTRY, ST_PENDING} state_t;

  // Keypad matrix position to printed glyph.
  function automatic logic [3:0] glyph_of(input logic [3:0] btn);
    logic [3:0] g;
    case (btn)
      4'd0:    g = 4'h1;
      4'd1:    g = 4'h4;
      4'd2:    g = 4'h7;
      4'd3:    g = 4'h0;
      4'd4:    g = 4'h2;
      4'd5:    g = 4'h5;
      4'd6:    g = 4'h8;
      4'd7:    g = 4'hF;
      4'd8:    g = 4'h3;
      4'd9:    g = 4'h6;
      4'd10:   g = 4'h9;
      4'd11:   g = 4'hE;
      4'd12:   g = 4'hA;
      4'd13:   g = 4'hB;
      4'd14:   g = 4'hC;
      default: g = 4'hD;
    endcase
    return g;
  endfunction

  // Glyphs A..E encode add, sub, mul, div, equals as 0..4.
  function automatic logic [2:0] op_of(input logic [3:0] glyph);
    logic [3:0] t;
    t = glyph - 4'hA;
    return t[2:0];
  endfunction

  state_t      state;
  logic [31:0] entry_r;
  logic        entry_neg_r;
  logic [3:0]  count_r;
  logic        overflow_r;
  logic        out_valid_r;
  logic [31:0] out_operand_r;
  logic        out_neg_r;
  logic [2:0]  out_op_r;
  logic        dropped_r;

  // ---- stage p0: key decode ----
  logic       vld_p0;
  logic       main_p0;
  logic [3:0] glyph_p0;
  logic       is_digit_p0;

  assign vld_p0      = bus.key[5];
  assign main_p0     = bus.key[4];
  assign glyph_p0    = glyph_of(bus.key[3:0]);
  assign is_digit_p0 = (glyph_p0 <= 4'd9);

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_ENTRY;
      entry_r       <= '0;
      entry_neg_r   <= 1'b0;
      count_r       <= '0;
      overflow_r    <= 1'b0;
      out_valid_r   <= 1'b0;
      out_operand_r <= '0;
      out_neg_r     <= 1'b0;
      out_op_r      <= '0;
      dropped_r     <= 1'b0;
    end else begin
      dropped_r <= 1'b0;
      case (state)
        ST_ENTRY: begin
          if (vld_p0 && main_p0) begin
            if (is_digit_p0) begin
              if (count_r == 4'd8) begin
                overflow_r <= 1'b1;
              end else if (!(glyph_p0 == 4'h0 && count_r == 4'd0)) begin
                // Leading zeros are swallowed so the count reflects
                // significant digits only.
                entry_r <= {entry_r[27:0], glyph_p0};
                count_r <= count_r + 4'd1;
              end
            end else if (glyph_p0 == 4'hF) begin
              entry_r     <= '0;
              entry_neg_r <= 1'b0;
              count_r     <= '0;
              overflow_r  <= 1'b0;
            end else begin
              out_operand_r <= entry_r;
              out_neg_r     <= entry_neg_r;
              out_op_r      <= op_of(glyph_p0);
              out_valid_r   <= 1'b1;
              state         <= ST_PENDING;
            end
          end
`ifdef KEY_ENTRY_ALT_EN
          else if (vld_p0 && !main_p0) begin
            if (glyph_p0 == 4'h1) begin
              if (count_r != 4'd0) begin
                entry_r    <= {4'h0, entry_r[31:4]};
                count_r    <= count_r - 4'd1;
                overflow_r <= 1'b0;
              end
            end else if (glyph_p0 == 4'h0) begin
              entry_neg_r <= ~entry_neg_r;
            end
          end
`endif
        end
        ST_PENDING: begin
          // Keys cannot be queued behind a waiting record; flag the loss.
          if (vld_p0 && (main_p0 || ALT_EN)) begin
            dropped_r <= 1'b1;
          end
          if (bus.out_ready) begin
            state       <= ST_ENTRY;
            out_valid_r <= 1'b0;
            entry_r     <= '0;
            entry_neg_r <= 1'b0;
            count_r     <= '0;
            overflow_r  <= 1'b0;
          end
        end
        default: state <= ST_ENTRY;
      endcase
    end
  end

  assign bus.entry       = entry_r;
  assign bus.entry_neg   = entry_neg_r;
  assign bus.digit_count = count_r;
  assign bus.overflow    = overflow_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_operand = out_operand_r;
  assign bus.out_neg     = out_neg_r;
  assign bus.out_op      = out_op_r;
  assign bus.dropped     = dropped_r;

endmodule

// File: tb/tb_key_entry.sv
// ----------------------------------------------------------------------------
// tb_key_entry
// Directed scenarios followed by random key/ready/reset traffic for
// key_entry. Expected outputs come from a reference model holding the
// operand as a list of entered digits.
// ----------------------------------------------------------------------------
module tb_key_entry;

`ifdef KEY_ENTRY_ALT_EN
  localparam bit ALT = 1'b1;
`else
  localparam bit ALT = 1'b0;
`endif

  logic clock;
  logic reset;
  key_entry_if bus();

  key_entry dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int vectors;
  int miscompares;

  // Reference model state.
  int unsigned mdig[$];
  bit          mneg;
  bit          movf;
  bit          mpend;
  bit          mdrop;
  logic [31:0] mrec_val;
  bit          mrec_neg;
  int          mrec_op;
  bit          rec_known;

  int glyph_tab[16] = '{1, 4, 7, 0, 2, 5, 8, 15, 3, 6, 9, 14, 10, 11, 12, 13};

  function automatic logic [31:0] m_entry();
    logic [31:0] e;
    e = 32'd0;
    foreach (mdig[i]) e = e * 16 + mdig[i];
    return e;
  endfunction

  function automatic logic [5:0] mk(input bit main, input int btn);
    logic [3:0] b;
    b = btn[3:0];
    return {1'b1, main, b};
  endfunction

  task automatic m_clear();
    mdig.delete();
    mneg = 1'b0;
    movf = 1'b0;
  endtask

  task automatic model_step(input logic [5:0] k, input logic rdy, input logic rst);
    int g;
    bit vld;
    bit main;
    vld  = k[5];
    main = k[4];
    g    = glyph_tab[k[3:0]];
    if (rst) begin
      m_clear();
      mpend = 0; mdrop = 0;
      mrec_val = 0; mrec_neg = 0; mrec_op = 0; rec_known = 1;
      return;
    end
    mdrop = 0;
    if (mpend) begin
      if (vld && (main || ALT)) mdrop = 1;
      if (rdy) begin
        mpend = 0;
        m_clear();
        rec_known = 0;
      end
    end else if (vld && main) begin
      if (g < 10) begin
        if (mdig.size() == 8) movf = 1;
        else if (!(g == 0 && mdig.size() == 0)) mdig.push_back(g);
      end else if (g == 15) begin
        m_clear();
      end else begin
        mrec_val = m_entry();
        mrec_neg = mneg;
        mrec_op  = g - 10;
        mpend    = 1;
        rec_known = 1;
      end
    end else if (vld && ALT) begin
      if (g == 1) begin
        if (mdig.size() > 0) begin
          void'(mdig.pop_back());
          movf = 0;
        end
      end else if (g == 0) begin
        mneg = !mneg;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h at %0t", name, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("entry", bus.entry, m_entry());
    chk("entry_neg", {31'd0, bus.entry_neg}, {31'd0, mneg});
    chk("digit_count", {28'd0, bus.digit_count}, mdig.size());
    chk("overflow", {31'd0, bus.overflow}, {31'd0, movf});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, mpend});
    chk("dropped", {31'd0, bus.dropped}, {31'd0, mdrop});
    if (rec_known) begin
      chk("out_operand", bus.out_operand, mrec_val);
      chk("out_neg", {31'd0, bus.out_neg}, {31'd0, mrec_neg});
      chk("out_op", {29'd0, bus.out_op}, mrec_op);
    end
  endtask

  // One clock: drive on the falling edge, update the model at the rising
  // edge, compare shortly after it.
  task automatic cycle(input logic [5:0] k, input logic rdy, input logic rst);
    @(negedge clock);
    bus.key       = k;
    bus.out_ready = rdy;
    reset         = rst;
    @(posedge clock);
    model_step(k, rdy, rst);
    #1 check_all();
  endtask

  initial begin
    logic [5:0] rk;
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.key = '0;
    bus.out_ready = 1'b0;
    m_clear();
    mpend = 0; mdrop = 0; rec_known = 0;

    // Reset state.
    cycle(6'd0, 1'b0, 1'b1);
    chk("rst_entry", bus.entry, 32'd0);
    chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_operand", bus.out_operand, 32'd0);
    cycle(6'd0, 1'b0, 1'b0);

    // 1, 2, 3.
    cycle(mk(1, 0), 0, 0);
    cycle(mk(1, 4), 0, 0);
    cycle(mk(1, 8), 0, 0);
    chk("s123_entry", bus.entry, 32'h0000_0123);
    chk("s123_count", {28'd0, bus.digit_count}, 32'd3);
    chk("s123_ovf", {31'd0, bus.overflow}, 32'd0);

    // Leading zeros ignored.
    cycle(mk(1, 7), 0, 0);
    cycle(mk(1, 3), 0, 0);
    cycle(mk(1, 3), 0, 0);
    chk("lz_count", {28'd0, bus.digit_count}, 32'd0);
    cycle(mk(1, 0), 0, 0);
    chk("lz_entry", bus.entry, 32'h0000_0001);
    chk("lz_count1", {28'd0, bus.digit_count}, 32'd1);

    // Fill to 8 digits, overflow, then clear-entry.
    cycle(mk(1, 7), 0, 0);
    foreach (glyph_tab[i]) if (i < 0) cycle(6'd0, 0, 0);
    cycle(mk(1, 0), 0, 0); cycle(mk(1, 4), 0, 0); cycle(mk(1, 8), 0, 0);
    cycle(mk(1, 1), 0, 0); cycle(mk(1, 5), 0, 0); cycle(mk(1, 9), 0, 0);
    cycle(mk(1, 2), 0, 0); cycle(mk(1, 6), 0, 0);
    cycle(mk(1, 10), 0, 0);
    chk("ovf_entry", bus.entry, 32'h1234_5678);
    chk("ovf_count", {28'd0, bus.digit_count}, 32'd8);
    chk("ovf_flag", {31'd0, bus.overflow}, 32'd1);
    cycle(mk(1, 7), 0, 0);
    chk("ce_entry", bus.entry, 32'd0);
    chk("ce_ovf", {31'd0, bus.overflow}, 32'd0);

    // Record held under back-pressure; key during wait is dropped.
    cycle(6'd0, 1, 0);  // ready with no record: no effect
    cycle(mk(1, 1), 0, 0);
    cycle(mk(1, 4), 0, 0);
    cycle(mk(1, 12), 0, 0);
    chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("hold_operand", bus.out_operand, 32'h42);
    chk("hold_op", {29'd0, bus.out_op}, 32'd0);
    for (int i = 0; i < 5; i++) cycle(6'd0, 0, 0);
    cycle(mk(1, 0), 0, 0);
    chk("hold_dropped", {31'd0, bus.dropped}, 32'd1);
    chk("hold_operand2", bus.out_operand, 32'h42);
    cycle(6'd0, 0, 0);
    chk("hold_dropped_end", {31'd0, bus.dropped}, 32'd0);
    cycle(mk(1, 8), 1, 0);  // key coincident with handshake
    chk("hs_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("hs_entry", bus.entry, 32'd0);
    chk("hs_dropped", {31'd0, bus.dropped}, 32'd1);

    // Alternate keyboard.
    cycle(mk(1, 0), 0, 0); cycle(mk(1, 4), 0, 0); cycle(mk(1, 8), 0, 0);
    cycle(mk(0, 0), 0, 0);
    if (ALT) chk("alt_bs_entry", bus.entry, 32'h12);
    else     chk("alt_off_entry", bus.entry, 32'h123);
    cycle(mk(0, 3), 0, 0);
    chk("alt_neg", {31'd0, bus.entry_neg}, {31'd0, ALT});
    cycle(mk(1, 14), 0, 0);
    chk("alt_out_neg", {31'd0, bus.out_neg}, {31'd0, ALT});
    chk("alt_out_op", {29'd0, bus.out_op}, 32'd2);
    cycle(mk(0, 5), 0, 0);
    chk("alt_pend_drop", {31'd0, bus.dropped}, {31'd0, ALT});

    // Reset while a record is pending.
    cycle(6'd0, 0, 1);
    chk("rp_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rp_operand", bus.out_operand, 32'd0);
    chk("rp_op", {29'd0, bus.out_op}, 32'd0);
    cycle(6'd0, 0, 0);

    // Random traffic.
    for (int n = 0; n < 800; n++) begin
      rk = 6'd0;
      if ($urandom_range(0, 9) < 7) begin
        rk[5] = 1'b1;
        rk[4] = ($urandom_range(0, 4) != 0);
        rk[3:0] = 4'($urandom_range(0, 15));
        // Favour digit keys so long entries and overflow occur.
        if ($urandom_range(0, 2) != 0) rk[3:0] = 4'(glyph_pos_of_digit($urandom_range(0, 9)));
      end
      cycle(rk, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  function automatic int glyph_pos_of_digit(input int d);
    int pos;
    pos = 3;
    foreach (glyph_tab[i]) if (glyph_tab[i] == d) pos = i;
    return pos;
  endfunction

endmodule
